// File: rtl/spart_pkg.sv
// Shared widths, pairing-FSM state type and byte-pairing helper for the SPART
// receive word assembler.
package spart_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } spart_rx_state_t;

    // hi_first=0 puts the first byte in the low half, hi_first=1 in the high half.
    function automatic logic [WORD_W-1:0] pair_bytes(
        input logic [BYTE_W-1:0] first_byte,
        input logic [BYTE_W-1:0] second_byte,
        input logic              hi_first
    );
        logic [WORD_W-1:0] word;
        if (hi_first) begin
            word = {first_byte, second_byte};
        end else begin
            word = {second_byte, first_byte};
        end
        return word;
    endfunction

endpackage

// File: rtl/spart_word_fifo.sv
// Show-ahead word FIFO: the head entry is presented combinationally from storage,
// push and pop may coincide (also when full), flush empties it synchronously.
module spart_word_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_ok_s  = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok_s = push & (~full | pop_ok_s) & ~flush;
    assign head      = empty ? {WORD_W{1'b0}} : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spart_rx_word_assembler.sv
// Pairs received SPART bytes into 16-bit words, buffers them in a show-ahead FIFO
// and flags read stalls and dropped words for the WB source select.
module spart_rx_word_assembler
    import spart_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int HI_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_valid,
    input  logic              rd_req,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic [WORD_W-1:0] rd_data,
    output logic              word_avail,
    output logic              stall,
    output logic              partial,
    output logic              overflow
);

    localparam logic HI_FIRST_B = (HI_FIRST != 0) ? 1'b1 : 1'b0;

    spart_rx_state_t   state_r;
    logic [BYTE_W-1:0] hold_r;
    logic              overflow_r;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [WORD_W-1:0] word_s;

    assign push_s = rx_valid & (state_r == WAIT_SECOND) & ~flush;
    assign pop_s  = rd_req & ~fifo_empty_s & ~flush;
    assign drop_s = push_s & fifo_full_s & ~pop_s;
    assign word_s = pair_bytes(hold_r, rx_byte, HI_FIRST_B);

    spart_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .flush     (flush),
        .head      (rd_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Byte-pairing FSM and first-byte hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_FIRST;
            hold_r  <= {BYTE_W{1'b0}};
        end else if (flush) begin
            state_r <= WAIT_FIRST;
            hold_r  <= {BYTE_W{1'b0}};
        end else begin
            case (state_r)
                WAIT_FIRST: begin
                    if (rx_valid) begin
                        hold_r  <= rx_byte;
                        state_r <= WAIT_SECOND;
                    end else begin
                        state_r <= WAIT_FIRST;
                    end
                end
                WAIT_SECOND: begin
                    if (rx_valid) begin
                        state_r <= WAIT_FIRST;
                    end else begin
                        state_r <= WAIT_SECOND;
                    end
                end
                default: begin
                    state_r <= WAIT_FIRST;
                    hold_r  <= {BYTE_W{1'b0}};
                end
            endcase
        end
    end

    // Sticky overflow: a fresh drop outranks a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign word_avail = ~fifo_empty_s;
    assign partial    = (state_r == WAIT_SECOND);
    assign overflow   = overflow_r;
    assign stall      = rd_req & fifo_empty_s;

endmodule
